// File: rtl/exu_stage_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, operand selects,
// control-transfer kinds and branch conditions. Also used by the IDU and ALU callers.
package exu_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SRL  = 3'd5,
    ALU_OR   = 3'd6,
    ALU_AND  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC1_RS1  = 2'd0,
    SRC1_PC   = 2'd1,
    SRC1_ZERO = 2'd2
  } src1_sel_e;

  typedef enum logic [1:0] {
    SRC2_RS2  = 2'd0,
    SRC2_IMM  = 2'd1,
    SRC2_FOUR = 2'd2
  } src2_sel_e;

  typedef enum logic [1:0] {
    CTL_NONE   = 2'd0,
    CTL_BRANCH = 2'd1,
    CTL_JAL    = 2'd2,
    CTL_JALR   = 2'd3
  } ctl_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd4,
    BR_GE  = 3'd5,
    BR_LTU = 3'd6,
    BR_GEU = 3'd7
  } br_cond_e;

  localparam logic [31:0] LINK_STEP = 32'd4;

endpackage

// File: rtl/exu_stage_alu.sv
// Combinational integer ALU. if_unsigned selects SUB for ADD and SRA for SRL.
module ysyx_23060124_ALU
  import exu_stage_pkg::*;
(
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        if_unsigned,
  input  logic [2:0]  opt,
  output logic [31:0] res
);

  logic [4:0] shamt;
  assign shamt = src2[4:0];

  // Opcode decode; the alternate bit only matters for ADD and SRL.
  always_comb begin
    res = 32'd0;
    case (opt)
      ALU_ADD:  res = if_unsigned ? (src1 - src2) : (src1 + src2);
      ALU_SLL:  res = src1 << shamt;
      ALU_SLT:  res = {31'd0, $signed(src1) < $signed(src2)};
      ALU_SLTU: res = {31'd0, src1 < src2};
      ALU_XOR:  res = src1 ^ src2;
      ALU_SRL:  res = if_unsigned ? 32'($signed(src1) >>> shamt) : (src1 >> shamt);
      ALU_OR:   res = src1 | src2;
      ALU_AND:  res = src1 & src2;
      default:  res = 32'd0;
    endcase
  end

endmodule

// File: rtl/exu_stage.sv
// Execute stage: operand selection, ALU, branch resolution and a single-entry
// output register with valid/ready on both sides. Taken control transfers
// produce a one-cycle redirect pulse aligned with the registered result.
module exu_stage
  import exu_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic [2:0]  in_alu_opt,
  input  logic        in_alu_alt,
  input  logic [1:0]  in_src1_sel,
  input  logic [1:0]  in_src2_sel,
  input  logic [1:0]  in_ctl,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  input  logic        in_mem_ren,
  input  logic        in_mem_wen,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [31:0] out_wdata,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_mem_ren,
  output logic        out_mem_wen,
  output logic [2:0]  out_funct3,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  logic        fire;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_res;
  logic        cond;
  logic        taken;
  logic [31:0] jalr_sum;
  logic [31:0] target;

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;

  // Operand muxes; the unused select code falls back to zero.
  always_comb begin
    src1 = 32'd0;
    src2 = 32'd0;
    case (in_src1_sel)
      SRC1_RS1:  src1 = in_rs1;
      SRC1_PC:   src1 = in_pc;
      default:   src1 = 32'd0;
    endcase
    case (in_src2_sel)
      SRC2_RS2:  src2 = in_rs2;
      SRC2_IMM:  src2 = in_imm;
      SRC2_FOUR: src2 = LINK_STEP;
      default:   src2 = 32'd0;
    endcase
  end

  ysyx_23060124_ALU u_alu (
    .src1        (src1),
    .src2        (src2),
    .if_unsigned (in_alu_alt),
    .opt         (in_alu_opt),
    .res         (alu_res)
  );

  // Branch comparator on raw register values; funct3 2/3 never take.
  always_comb begin
    cond = 1'b0;
    case (in_funct3)
      BR_EQ:   cond = (in_rs1 == in_rs2);
      BR_NE:   cond = (in_rs1 != in_rs2);
      BR_LT:   cond = ($signed(in_rs1) <  $signed(in_rs2));
      BR_GE:   cond = ($signed(in_rs1) >= $signed(in_rs2));
      BR_LTU:  cond = (in_rs1 <  in_rs2);
      BR_GEU:  cond = (in_rs1 >= in_rs2);
      default: cond = 1'b0;
    endcase
  end

  assign jalr_sum = in_rs1 + in_imm;

  // Target adder and taken decision.
  always_comb begin
    taken  = 1'b0;
    target = in_pc + in_imm;
    case (in_ctl)
      CTL_BRANCH: taken = cond;
      CTL_JAL:    taken = 1'b1;
      CTL_JALR: begin
        taken  = 1'b1;
        target = {jalr_sum[31:1], 1'b0};
      end
      default:    taken = 1'b0;
    endcase
  end

  // Output register: load on fire, drop valid on drain without a new fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_res     <= 32'd0;
      out_wdata   <= 32'd0;
      out_rd      <= 5'd0;
      out_wen     <= 1'b0;
      out_mem_ren <= 1'b0;
      out_mem_wen <= 1'b0;
      out_funct3  <= 3'd0;
    end else if (fire) begin
      out_valid   <= 1'b1;
      out_res     <= alu_res;
      out_wdata   <= in_rs2;
      out_rd      <= in_rd;
      out_wen     <= in_wen;
      out_mem_ren <= in_mem_ren;
      out_mem_wen <= in_mem_wen;
      out_funct3  <= in_funct3;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // Redirect pulse: set only by a taken fire, so it cannot outlast one cycle
  // unless another taken instruction fires right behind it.
  always_ff @(posedge clock) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= fire && taken;
      if (fire && taken) begin
        redirect_pc <= target;
      end
    end
  end

endmodule
